hazard_controller: RTL and testbench

- Sequencing controller for the 5-stage RV32 pipeline datapath (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Generates per-stage enable, flush and bubble controls for three cases: load-use hazards, control redirects resolved in MEM, and multi-cycle data-memory accesses signalled by a ready handshake.
- Keeps saturating stall and flush event counters and enters a fault state on memory timeout.
- Sits beside the forwarding unit; the datapath register-enable and clear inputs are driven only from here.

---
 rtl/pipe_ctrl_pkg.sv | 66 ++++++
 rtl/load_use_detect.sv | 30 +++
 rtl/hazard_controller.sv | 164 ++++++++++++++++
 tb/tb_hazard_controller.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and constants for the pipeline hazard controller
//
// Purpose : FSM state encoding, the x0 register constant, the bundled
//           stage-control struct with its canonical patterns, and the
//           helper that overlays redirect / load-use controls on a base pattern.
// Ports   : none (package)
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      FAULT    = 2'd2
   } ctrl_state_e;

   localparam logic [4:0] REG_ZERO = 5'd0;

   typedef struct packed {
      logic dmem_req;
      logic pc_en;
      logic if_id_en;
      logic if_id_flush;
      logic id_ex_en;
      logic id_ex_flush;
      logic ex_mem_en;
      logic ex_mem_flush;
      logic mem_wb_bubble;
   } stage_ctrl_t;

   // Every stage advances, nothing cleared, no memory request.
   localparam stage_ctrl_t CTRL_RUN = '{
      dmem_req: 1'b0, pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b0,
      id_ex_en: 1'b1, id_ex_flush: 1'b0, ex_mem_en: 1'b1, ex_mem_flush: 1'b0,
      mem_wb_bubble: 1'b0
   };

   // Outstanding data access: hold everything up to EX/MEM and push a NOP into WB.
   localparam stage_ctrl_t CTRL_FREEZE = '{
      dmem_req: 1'b1, pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b0,
      id_ex_en: 1'b0, id_ex_flush: 1'b0, ex_mem_en: 1'b0, ex_mem_flush: 1'b0,
      mem_wb_bubble: 1'b1
   };

   // Pipeline fully stopped after a memory timeout.
   localparam stage_ctrl_t CTRL_HALT = '0;

   // A redirect wins over a load-use stall: the stalled consumer is on the
   // wrong path and is flushed anyway.
   function automatic stage_ctrl_t apply_hazard(input stage_ctrl_t base,
                                                input logic        redirect,
                                                input logic        load_use);
      stage_ctrl_t c;
      c = base;
      if (redirect) begin
         c.pc_en        = 1'b1;
         c.if_id_flush  = 1'b1;
         c.id_ex_flush  = 1'b1;
         c.ex_mem_flush = 1'b1;
      end else if (load_use) begin
         c.pc_en       = 1'b0;
         c.if_id_en    = 1'b0;
         c.id_ex_flush = 1'b1;
      end
      return c;
   endfunction

endpackage

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - combinational load-use hazard detector
//
// Purpose : flags an ID instruction that reads the destination of a load
//           currently in EX; writes to x0 never create a dependency.
// Ports   : rs1_id/rs2_id     ID source register fields
//           use_rs1_id/use_rs2_id  ID instruction actually reads the field
//           rd_ex, mem_read_ex EX destination and load qualifier
//           load_use          one-bubble stall request
module load_use_detect
   import pipe_ctrl_pkg::*;
(
   input  logic [4:0] rs1_id,
   input  logic [4:0] rs2_id,
   input  logic       use_rs1_id,
   input  logic       use_rs2_id,
   input  logic [4:0] rd_ex,
   input  logic       mem_read_ex,
   output logic       load_use
);

   logic rs1_hit;
   logic rs2_hit;

   always_comb begin
      rs1_hit  = use_rs1_id && (rs1_id == rd_ex);
      rs2_hit  = use_rs2_id && (rs2_id == rd_ex);
      load_use = mem_read_ex && (rd_ex != REG_ZERO) && (rs1_hit || rs2_hit);
   end

endmodule

// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - stall/flush/bubble sequencer for the 5-stage RV32 pipeline
//
// Purpose : drives the PC and pipeline-register enables/clears for load-use
//           stalls, MEM-stage redirects and multi-cycle data-memory accesses;
//           counts stall cycles and redirects; faults on memory timeout.
// Ports   : clk, rst_n                 clock, synchronous active-low reset
//           rs1_id..mem_read_ex        load-use detection inputs
//           redirect_mem               taken branch/jump resolved in MEM
//           mem_access_mem, dmem_ready data access in MEM and its completion
//           dmem_req                   request qualifier to the data RAM
//           pc_en .. mem_wb_bubble     stage enables, clears and WB bubble
//           fault                      sticky memory-timeout flag
//           stall_cnt, flush_cnt       saturating event counters
module hazard_controller
   import pipe_ctrl_pkg::*;
#(
   parameter int CNT_W    = 32,
   parameter int WAIT_MAX = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       rs1_id,
   input  logic [4:0]       rs2_id,
   input  logic             use_rs1_id,
   input  logic             use_rs2_id,
   input  logic [4:0]       rd_ex,
   input  logic             mem_read_ex,
   input  logic             redirect_mem,
   input  logic             mem_access_mem,
   input  logic             dmem_ready,
   output logic             dmem_req,
   output logic             pc_en,
   output logic             if_id_en,
   output logic             if_id_flush,
   output logic             id_ex_en,
   output logic             id_ex_flush,
   output logic             ex_mem_en,
   output logic             ex_mem_flush,
   output logic             mem_wb_bubble,
   output logic             fault,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int                WAIT_W    = $clog2(WAIT_MAX + 1);
   // The counter already holds 1 for the cycle spent in RUN, so the
   // transition fires when the value before increment is WAIT_MAX-1.
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_MAX - 1);
   localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
   localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

   ctrl_state_e       state_q, state_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              fault_q, fault_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

   logic              load_use;
   logic              stall_evt;
   logic              flush_evt;
   stage_ctrl_t       ctrl;

   load_use_detect u_load_use_detect (
      .rs1_id      (rs1_id),
      .rs2_id      (rs2_id),
      .use_rs1_id  (use_rs1_id),
      .use_rs2_id  (use_rs2_id),
      .rd_ex       (rd_ex),
      .mem_read_ex (mem_read_ex),
      .load_use    (load_use)
   );

   always_comb begin
      ctrl      = CTRL_RUN;
      state_d   = state_q;
      wait_d    = wait_q;
      fault_d   = fault_q;
      stall_evt = 1'b0;
      flush_evt = 1'b0;

      case (state_q)
         RUN: begin
            if (mem_access_mem && !dmem_ready) begin
               ctrl    = CTRL_FREEZE;
               state_d = MEM_WAIT;
               wait_d  = WAIT_ONE;
            end else begin
               ctrl          = CTRL_RUN;
               ctrl.dmem_req = mem_access_mem;
               ctrl          = apply_hazard(ctrl, redirect_mem, load_use);
               flush_evt     = redirect_mem;
               stall_evt     = load_use && !redirect_mem;
            end
         end
         MEM_WAIT: begin
            stall_evt = 1'b1;
            if (dmem_ready) begin
               // Release in the completing cycle; younger hazards are
               // resolved now rather than costing an extra cycle.
               ctrl          = CTRL_RUN;
               ctrl.dmem_req = 1'b1;
               ctrl          = apply_hazard(ctrl, redirect_mem, load_use);
               flush_evt     = redirect_mem;
               state_d       = RUN;
               wait_d        = '0;
            end else if (wait_q >= WAIT_LAST) begin
               ctrl    = CTRL_FREEZE;
               state_d = FAULT;
               fault_d = 1'b1;
            end else begin
               ctrl   = CTRL_FREEZE;
               wait_d = wait_q + WAIT_ONE;
            end
         end
         FAULT: begin
            ctrl    = CTRL_HALT;
            fault_d = 1'b1;
         end
         default: begin
            ctrl    = CTRL_HALT;
            state_d = RUN;
         end
      endcase

      stall_cnt_d = (stall_evt && stall_cnt_q != CNT_MAX) ? stall_cnt_q + CNT_ONE : stall_cnt_q;
      flush_cnt_d = (flush_evt && flush_cnt_q != CNT_MAX) ? flush_cnt_q + CNT_ONE : flush_cnt_q;

      // While in reset the datapath free-runs and any pending access is dropped.
      if (!rst_n) begin
         ctrl = CTRL_RUN;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= RUN;
         wait_q      <= '0;
         fault_q     <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         wait_q      <= wait_d;
         fault_q     <= fault_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign dmem_req      = ctrl.dmem_req;
   assign pc_en         = ctrl.pc_en;
   assign if_id_en      = ctrl.if_id_en;
   assign if_id_flush   = ctrl.if_id_flush;
   assign id_ex_en      = ctrl.id_ex_en;
   assign id_ex_flush   = ctrl.id_ex_flush;
   assign ex_mem_en     = ctrl.ex_mem_en;
   assign ex_mem_flush  = ctrl.ex_mem_flush;
   assign mem_wb_bubble = ctrl.mem_wb_bubble;
   assign fault         = fault_q;
   assign stall_cnt     = stall_cnt_q;
   assign flush_cnt     = flush_cnt_q;

endmodule

// File: tb/tb_hazard_controller.sv
// tb/tb_hazard_controller.sv - directed self-checking bench for hazard_controller
module tb_hazard_controller;

   localparam int CNT_W    = 4;
   localparam int WAIT_MAX = 4;

   // Control vector order: {dmem_req, pc_en, if_id_en, if_id_flush, id_ex_en,
   //                        id_ex_flush, ex_mem_en, ex_mem_flush, mem_wb_bubble}
   localparam logic [8:0] V_NORM      = 9'b011010100;
   localparam logic [8:0] V_LU        = 9'b000011100;
   localparam logic [8:0] V_REDIR     = 9'b011111110;
   localparam logic [8:0] V_FREEZE    = 9'b100000001;
   localparam logic [8:0] V_RELEASE   = 9'b111010100;
   localparam logic [8:0] V_REL_REDIR = 9'b111111110;
   localparam logic [8:0] V_REL_LU    = 9'b100011100;
   localparam logic [8:0] V_HALT      = 9'b000000000;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [4:0]       rs1_id, rs2_id, rd_ex;
   logic             use_rs1_id, use_rs2_id, mem_read_ex;
   logic             redirect_mem, mem_access_mem, dmem_ready;
   logic             dmem_req, pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
   logic             ex_mem_en, ex_mem_flush, mem_wb_bubble, fault;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;
   logic [8:0]       ctrl_v;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   hazard_controller #(.CNT_W(CNT_W), .WAIT_MAX(WAIT_MAX)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .rs1_id         (rs1_id),
      .rs2_id         (rs2_id),
      .use_rs1_id     (use_rs1_id),
      .use_rs2_id     (use_rs2_id),
      .rd_ex          (rd_ex),
      .mem_read_ex    (mem_read_ex),
      .redirect_mem   (redirect_mem),
      .mem_access_mem (mem_access_mem),
      .dmem_ready     (dmem_ready),
      .dmem_req       (dmem_req),
      .pc_en          (pc_en),
      .if_id_en       (if_id_en),
      .if_id_flush    (if_id_flush),
      .id_ex_en       (id_ex_en),
      .id_ex_flush    (id_ex_flush),
      .ex_mem_en      (ex_mem_en),
      .ex_mem_flush   (ex_mem_flush),
      .mem_wb_bubble  (mem_wb_bubble),
      .fault          (fault),
      .stall_cnt      (stall_cnt),
      .flush_cnt      (flush_cnt)
   );

   assign ctrl_v = {dmem_req, pc_en, if_id_en, if_id_flush, id_ex_en,
                    id_ex_flush, ex_mem_en, ex_mem_flush, mem_wb_bubble};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic idle();
      rs1_id = 5'd0; rs2_id = 5'd0; rd_ex = 5'd0;
      use_rs1_id = 1'b0; use_rs2_id = 1'b0; mem_read_ex = 1'b0;
      redirect_mem = 1'b0; mem_access_mem = 1'b0; dmem_ready = 1'b1;
   endtask

   task automatic set_load_use();
      mem_read_ex = 1'b1; rd_ex = 5'd5; rs2_id = 5'd5; use_rs2_id = 1'b1;
   endtask

   // Returns 2 time units after the rising edge, well clear of it.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   initial begin
      idle();
      rst_n = 1'b0;
      mem_access_mem = 1'b1;
      dmem_ready = 1'b0;
      #1;
      check("rst_ctrl", 32'(ctrl_v), 32'(V_NORM));
      tick();
      check("rst_stall", 32'(stall_cnt), 32'd0);
      check("rst_flush", 32'(flush_cnt), 32'd0);
      check("rst_fault", 32'(fault), 32'd0);
      check("rst_state", 32'(dut.state_q), 32'd0);

      // load-use via rs2
      rst_n = 1'b1;
      idle();
      set_load_use();
      #1;
      check("lu_ctrl", 32'(ctrl_v), 32'(V_LU));
      tick();
      check("lu_stall", 32'(stall_cnt), 32'd1);
      idle();
      #1;
      check("lu_next_ctrl", 32'(ctrl_v), 32'(V_NORM));
      tick();
      check("lu_next_stall", 32'(stall_cnt), 32'd1);

      // load-use via rs1
      mem_read_ex = 1'b1; rd_ex = 5'd7; rs1_id = 5'd7; use_rs1_id = 1'b1;
      #1;
      check("lu_rs1_ctrl", 32'(ctrl_v), 32'(V_LU));
      tick();
      check("lu_rs1_stall", 32'(stall_cnt), 32'd2);
      use_rs1_id = 1'b0;
      #1;
      check("lu_nouse_ctrl", 32'(ctrl_v), 32'(V_NORM));
      tick();

      // x0 never stalls
      idle();
      mem_read_ex = 1'b1; rd_ex = 5'd0; rs2_id = 5'd0; use_rs2_id = 1'b1;
      #1;
      check("x0_ctrl", 32'(ctrl_v), 32'(V_NORM));
      tick();
      check("x0_stall", 32'(stall_cnt), 32'd2);

      // redirect overrides simultaneous load-use
      idle();
      set_load_use();
      redirect_mem = 1'b1;
      #1;
      check("redir_ctrl", 32'(ctrl_v), 32'(V_REDIR));
      tick();
      check("redir_flush", 32'(flush_cnt), 32'd1);
      check("redir_stall", 32'(stall_cnt), 32'd2);

      // memory wait: 3 not-ready cycles then release
      idle();
      set_load_use();
      redirect_mem = 1'b1;
      mem_access_mem = 1'b1; dmem_ready = 1'b0;
      #1;
      check("mw_c1_ctrl", 32'(ctrl_v), 32'(V_FREEZE));
      tick();
      check("mw_c1_state", 32'(dut.state_q), 32'd1);
      check("mw_c1_stall", 32'(stall_cnt), 32'd2);
      idle();
      mem_access_mem = 1'b1; dmem_ready = 1'b0;
      #1;
      check("mw_c2_ctrl", 32'(ctrl_v), 32'(V_FREEZE));
      tick();
      #1;
      check("mw_c3_ctrl", 32'(ctrl_v), 32'(V_FREEZE));
      tick();
      dmem_ready = 1'b1;
      #1;
      check("mw_rel_ctrl", 32'(ctrl_v), 32'(V_RELEASE));
      tick();
      check("mw_stall", 32'(stall_cnt), 32'd5);
      check("mw_flush", 32'(flush_cnt), 32'd1);
      check("mw_state", 32'(dut.state_q), 32'd0);

      // release together with a redirect
      idle();
      mem_access_mem = 1'b1; dmem_ready = 1'b0;
      tick();
      dmem_ready = 1'b1; redirect_mem = 1'b1;
      #1;
      check("rel_redir_ctrl", 32'(ctrl_v), 32'(V_REL_REDIR));
      tick();
      check("rel_redir_flush", 32'(flush_cnt), 32'd2);
      check("rel_redir_stall", 32'(stall_cnt), 32'd6);

      // release together with a load-use: single stall increment
      idle();
      mem_access_mem = 1'b1; dmem_ready = 1'b0;
      tick();
      dmem_ready = 1'b1;
      set_load_use();
      #1;
      check("rel_lu_ctrl", 32'(ctrl_v), 32'(V_REL_LU));
      tick();
      check("rel_lu_stall", 32'(stall_cnt), 32'd7);
      check("rel_lu_state", 32'(dut.state_q), 32'd0);

      // saturation: 20 load-use events from 7 clamp at 15
      idle();
      set_load_use();
      for (int i = 0; i < 20; i++) begin
         tick();
      end
      check("sat_stall", 32'(stall_cnt), 32'd15);

      // timeout
      idle();
      mem_access_mem = 1'b1; dmem_ready = 1'b0;
      tick();
      tick();
      tick();
      check("to_pre_fault", 32'(fault), 32'd0);
      check("to_pre_state", 32'(dut.state_q), 32'd1);
      tick();
      check("to_fault", 32'(fault), 32'd1);
      check("to_state", 32'(dut.state_q), 32'd2);
      check("to_ctrl", 32'(ctrl_v), 32'(V_HALT));
      dmem_ready = 1'b1; redirect_mem = 1'b1;
      tick();
      check("to_sticky_state", 32'(dut.state_q), 32'd2);
      check("to_sticky_ctrl", 32'(ctrl_v), 32'(V_HALT));

      rst_n = 1'b0;
      #1;
      check("to_rst_ctrl", 32'(ctrl_v), 32'(V_NORM));
      tick();
      check("to_rst_fault", 32'(fault), 32'd0);
      check("to_rst_stall", 32'(stall_cnt), 32'd0);
      check("to_rst_flush", 32'(flush_cnt), 32'd0);
      check("to_rst_state", 32'(dut.state_q), 32'd0);

      // reset in the middle of a memory wait
      rst_n = 1'b1;
      idle();
      mem_access_mem = 1'b1; dmem_ready = 1'b0;
      tick();
      tick();
      check("mwrst_stall", 32'(stall_cnt), 32'd1);
      rst_n = 1'b0;
      #1;
      check("mwrst_ctrl", 32'(ctrl_v), 32'(V_NORM));
      tick();
      check("mwrst_state", 32'(dut.state_q), 32'd0);
      check("mwrst_cnt", 32'(stall_cnt), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
